// File: rtl/sprite_pkg.sv
// Shared sprite constants: screen size, blitter state encoding and default sprite geometry.
// Imported by the blitter and by whatever level muxes the sprite ROMs.
package sprite_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    localparam int unsigned SHIP_W  = 16;
    localparam int unsigned SHIP_H  = 8;
    localparam int unsigned ENEMY_W = 8;
    localparam int unsigned ENEMY_H = 8;

    localparam int unsigned DEF_COLOR_W = 8;

    typedef logic [1:0] blit_state_t;

    localparam blit_state_t StIdle  = 2'd0;
    localparam blit_state_t StFetch = 2'd1;
    localparam blit_state_t StDraw  = 2'd2;
    localparam blit_state_t StDone  = 2'd3;

    // Coordinates arrive 11 bits wide so a sum that crossed 1023 still compares correctly.
    function automatic logic on_screen(input logic [10:0] px, input logic [10:0] py);
        return (px < 11'(SCREEN_W)) && (py < 11'(SCREEN_H));
    endfunction

endpackage

// File: rtl/sprite_blitter.sv
// Walks a sprite bitmap row by row from a combinational ROM and emits one clipped
// pixel write per set bit, one column per cycle, with back-pressure from the framebuffer.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W = SHIP_W,
    parameter int unsigned SPRITE_H = SHIP_H,
    parameter int unsigned COLOR_W  = DEF_COLOR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [9:0]          req_x,
    input  logic [9:0]          req_y,
    input  logic [7:0]          req_base,
    input  logic [COLOR_W-1:0]  req_color,
    output logic [7:0]          rom_addr,
    input  logic [SPRITE_W-1:0] rom_data,
    output logic                pix_we,
    input  logic                pix_ready,
    output logic [9:0]          pix_x,
    output logic [9:0]          pix_y,
    output logic [COLOR_W-1:0]  pix_color,
    output logic                done
);

    localparam int unsigned CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    blit_state_t         state_q, state_d;
    logic [9:0]          x_q, x_d;
    logic [9:0]          y_q, y_d;
    logic [7:0]          base_q, base_d;
    logic [COLOR_W-1:0]  color_q, color_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic [SPRITE_W-1:0] bits_q, bits_d;
    logic [7:0]          rom_addr_q, rom_addr_d;

    logic        in_draw;
    logic [10:0] px_full;
    logic [10:0] py_full;
    logic        stall;
    logic        last_col;
    logic        last_row;

    // bits_q shifts left each column, so its MSB is always the pixel for col_q.
    always_comb begin
        in_draw  = (state_q == StDraw);
        px_full  = {1'b0, x_q} + 11'(col_q);
        py_full  = {1'b0, y_q} + 11'(row_q);
        pix_we   = in_draw && bits_q[SPRITE_W-1] && on_screen(px_full, py_full);
        stall    = pix_we && !pix_ready;
        last_col = (col_q == CW'(SPRITE_W - 1));
        last_row = (row_q == RW'(SPRITE_H - 1));
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        done      = (state_q == StDone);
        rom_addr  = rom_addr_q;
        pix_x     = in_draw ? px_full[9:0] : '0;
        pix_y     = in_draw ? py_full[9:0] : '0;
        pix_color = in_draw ? color_q : '0;
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        base_d     = base_q;
        color_d    = color_q;
        row_d      = row_q;
        col_d      = col_q;
        bits_d     = bits_q;
        rom_addr_d = rom_addr_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    x_d        = req_x;
                    y_d        = req_y;
                    base_d     = req_base;
                    color_d    = req_color;
                    row_d      = '0;
                    rom_addr_d = req_base;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                bits_d  = rom_data;
                col_d   = '0;
                state_d = StDraw;
            end
            StDraw: begin
                if (!stall) begin
                    bits_d = bits_q << 1;
                    if (last_col) begin
                        if (last_row) begin
                            state_d = StDone;
                        end else begin
                            row_d      = row_q + RW'(1);
                            rom_addr_d = base_q + 8'(row_q) + 8'd1;
                            state_d    = StFetch;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            base_q     <= '0;
            color_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            bits_q     <= '0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            base_q     <= base_d;
            color_q    <= color_d;
            row_q      <= row_d;
            col_q      <= col_d;
            bits_q     <= bits_d;
            rom_addr_q <= rom_addr_d;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: a 16x8 ship instance and an 8x8 enemy instance
// share stimulus; expected pixel streams come from a per-pixel model of the sprite bitmaps.
module tb_sprite_blitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid16;
    logic       req_valid8;
    logic [9:0] req_x;
    logic [9:0] req_y;
    logic [7:0] req_base;
    logic [7:0] req_color;
    logic       pix_ready;

    logic        req_ready16, pix_we16, done16;
    logic [7:0]  rom_addr16;
    logic [15:0] rom_data16;
    logic [9:0]  pix_x16, pix_y16;
    logic [7:0]  pix_color16;

    logic        req_ready8, pix_we8, done8;
    logic [7:0]  rom_addr8;
    logic [7:0]  rom_data8;
    logic [9:0]  pix_x8, pix_y8;
    logic [7:0]  pix_color8;

    logic [15:0] rom16 [256];
    logic [7:0]  rom8  [256];

    int n_pass  = 0;
    int n_total = 0;
    int cur_sel = 0;

    logic       obs_ready, obs_we, obs_done;
    logic [7:0] obs_rom_addr, obs_color;
    logic [9:0] obs_x, obs_y;

    always #5 clk = ~clk;

    assign rom_data16 = rom16[rom_addr16];
    assign rom_data8  = rom8[rom_addr8];

    sprite_blitter #(.SPRITE_W(16), .SPRITE_H(8), .COLOR_W(8)) dut16 (
        .clk(clk), .reset(reset), .req_valid(req_valid16), .req_ready(req_ready16),
        .req_x(req_x), .req_y(req_y), .req_base(req_base), .req_color(req_color),
        .rom_addr(rom_addr16), .rom_data(rom_data16), .pix_we(pix_we16),
        .pix_ready(pix_ready), .pix_x(pix_x16), .pix_y(pix_y16), .pix_color(pix_color16),
        .done(done16)
    );

    sprite_blitter #(.SPRITE_W(8), .SPRITE_H(8), .COLOR_W(8)) dut8 (
        .clk(clk), .reset(reset), .req_valid(req_valid8), .req_ready(req_ready8),
        .req_x(req_x), .req_y(req_y), .req_base(req_base), .req_color(req_color),
        .rom_addr(rom_addr8), .rom_data(rom_data8), .pix_we(pix_we8),
        .pix_ready(pix_ready), .pix_x(pix_x8), .pix_y(pix_y8), .pix_color(pix_color8),
        .done(done8)
    );

    always_comb begin
        if (cur_sel != 0) begin
            obs_ready = req_ready8;  obs_we = pix_we8;  obs_done = done8;
            obs_rom_addr = rom_addr8; obs_x = pix_x8; obs_y = pix_y8; obs_color = pix_color8;
        end else begin
            obs_ready = req_ready16; obs_we = pix_we16; obs_done = done16;
            obs_rom_addr = rom_addr16; obs_x = pix_x16; obs_y = pix_y16; obs_color = pix_color16;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(obs_ready), 32'd1);
        check({tag, "_rom_addr"},  32'(obs_rom_addr), 32'd0);
        check({tag, "_pix_we"},    32'(obs_we), 32'd0);
        check({tag, "_pix_x"},     32'(obs_x), 32'd0);
        check({tag, "_pix_y"},     32'(obs_y), 32'd0);
        check({tag, "_pix_color"}, 32'(obs_color), 32'd0);
        check({tag, "_done"},      32'(obs_done), 32'd0);
    endtask

    // One sprite draw: cycle 0 is the acceptance cycle, each loop pass is one later cycle.
    task automatic run_sprite(input int sel, input int x, input int y, input int base,
                              input int color, input int stall_len, input int reset_at,
                              input bit hold, input int exp_writes);
        logic [27:0] exp_q[$];
        logic [27:0] held, want;
        logic [15:0] row;
        int w, exp_done, exp_total, stall_left, writes, k;
        bit stalled_prev, finished;

        w = (sel != 0) ? 8 : 16;
        for (int r = 0; r < 8; r++) begin
            row = (sel != 0) ? {8'h00, rom8[(base + r) % 256]} : rom16[(base + r) % 256];
            for (int c = 0; c < w; c++)
                if (row[w-1-c] && (x + c) < 640 && (y + r) < 480)
                    exp_q.push_back({10'(x + c), 10'(y + r), 8'(color)});
        end
        exp_total = exp_q.size();
        exp_done  = 8 * (w + 1) + 1 + ((exp_total > 0) ? stall_len : 0);

        cur_sel = sel;
        @(negedge clk);
        req_x = 10'(x); req_y = 10'(y); req_base = 8'(base); req_color = 8'(color);
        pix_ready = 1'b1;
        if (sel != 0) req_valid8 = 1'b1; else req_valid16 = 1'b1;
        check("accept_ready", 32'(obs_ready), 32'd1);

        stall_left = stall_len; writes = 0; stalled_prev = 1'b0; finished = 1'b0;
        held = '0;
        for (k = 1; k <= 400 && !finished; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (!hold) begin req_valid16 = 1'b0; req_valid8 = 1'b0; end
                req_x = 10'($urandom); req_y = 10'($urandom);
                req_base = 8'($urandom); req_color = 8'($urandom);
            end
            if (reset_at > 0 && k == reset_at + 1) begin
                reset = 1'b0;
                check_reset_outputs("mid_reset");
                finished = 1'b1;
            end else begin
                if (k <= exp_done) check("busy_ready", 32'(obs_ready), 32'd0);
                pix_ready = !(obs_we && stall_left > 0);
                if (stalled_prev)
                    check("stall_hold", 32'({obs_x, obs_y, obs_color}), 32'(held));
                if (obs_we && !pix_ready) begin
                    stall_left--;
                    held = {obs_x, obs_y, obs_color};
                    stalled_prev = 1'b1;
                end else begin
                    stalled_prev = 1'b0;
                end
                if (obs_we && pix_ready) begin
                    writes++;
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : 28'hFFFFFFF;
                    check("pixel", 32'({obs_x, obs_y, obs_color}), 32'(want));
                end
                if (reset_at == k) reset = 1'b1;
                if (obs_done) begin
                    check("done_cycle", 32'(k), 32'(exp_done));
                    check("write_total", 32'(writes), 32'(exp_total));
                    if (exp_writes >= 0) check("write_spec", 32'(writes), 32'(exp_writes));
                    finished = 1'b1;
                end
            end
        end
        if (!finished) check("timeout", 32'(k), 32'(exp_done));
    endtask

    initial begin
        logic [15:0] ship [8];
        logic [7:0]  enemy [8];
        ship  = '{16'h0180, 16'h03C0, 16'h07E0, 16'h0FF0, 16'h1FF8,
                  16'h0240, 16'h0420, 16'h0810};
        enemy = '{8'hC3, 8'h3C, 8'h7E, 8'hDB, 8'hFF, 8'h24, 8'h5A, 8'h81};
        for (int i = 0; i < 256; i++) begin
            rom16[i] = 16'($urandom);
            rom8[i]  = 8'($urandom);
        end
        for (int i = 0; i < 8; i++) begin
            rom16[16 + i] = ship[i];
            rom8[i]       = enemy[i];
        end

        reset = 1'b1; req_valid16 = 1'b0; req_valid8 = 1'b0; pix_ready = 1'b1;
        req_x = '0; req_y = '0; req_base = '0; req_color = '0;
        repeat (3) @(negedge clk);
        cur_sel = 0;
        check_reset_outputs("reset16");
        cur_sel = 1;
        check_reset_outputs("reset8");
        reset = 1'b0;

        // ship sprite at ROM base 0x10: plain, right clip, bottom clip, stall, mid-draw reset
        run_sprite(0, 100, 50, 16, 8'h5A, 0, 0, 1'b0, 36);
        run_sprite(0, 630, 50, 16, 8'hA5, 0, 0, 1'b0, -1);
        run_sprite(0, 100, 475, 16, 8'h33, 0, 0, 1'b0, -1);
        run_sprite(0, 100, 50, 16, 8'h77, 5, 0, 1'b0, 36);
        run_sprite(0, 200, 100, 16, 8'h11, 0, 40, 1'b0, -1);
        run_sprite(0, 639, 479, 16, 8'hEE, 0, 0, 1'b0, -1);
        run_sprite(0, 10, 10, 8'hFD, 8'h42, 2, 0, 1'b0, -1);

        // enemy with a second request held through the whole draw
        run_sprite(1, 0, 0, 0, 8'hC0, 0, 0, 1'b1, -1);
        run_sprite(1, 20, 30, 0, 8'h0F, 0, 0, 1'b0, -1);

        for (int i = 0; i < 6; i++)
            run_sprite(int'($urandom_range(0, 1)), int'($urandom_range(0, 639)),
                       int'($urandom_range(0, 479)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 0, 1'b0, -1);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Consumer end of the sprite ROM interface. The blitter accepts a draw request (screen position, ROM base row, colour) and walks the sprite bitmap one row at a time by driving the ROM address. It emits one pixel-write per set bit into the frame/line buffer writer, clipping pixels that fall off-screen. It sits between the game-object logic (ship, enemies) and the framebuffer write port, and serves any combinational `*_rom` with an 8-bit address and a SPRITE_W-bit row output.

## Interface
- SPRITE_W, 16: bits per ROM row. Bit SPRITE_W-1 is the leftmost pixel.
- SPRITE_H, 8: rows per sprite.
- COLOR_W, 8: pixel colour width.
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  draw request present.
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready.
- req_x  in  10  screen X of the sprite's left column (0..639).
- req_y  in  10  screen Y of the sprite's top row (0..479).
- req_base  in  8  ROM address of the sprite's row 0.
- req_color  in  COLOR_W  colour written for set bits.
- rom_addr  out  8  ROM row address (registered).
- rom_data  in  SPRITE_W  combinational ROM output for rom_addr.
- pix_we  out  1  pixel write valid.
- pix_ready  in  1  framebuffer accepts the write; transfer = pix_we & pix_ready.
- pix_x  out  10  pixel X.
- pix_y  out  10  pixel Y.
- pix_color  out  COLOR_W  pixel colour.
- done  out  1  one-cycle pulse when a sprite finishes.

## Operation
- States: IDLE, FETCH, DRAW, DONE.
- IDLE: req_ready=1. On acceptance, latch req_x/req_y/req_base/req_color, set row=0, and go to FETCH.
- FETCH (1 cycle): rom_addr = base + row (8-bit, wraps mod 256). At the exiting edge, capture rom_data into the row register, set col=0, and go to DRAW.
- DRAW: one column per cycle, MSB first.
  - pix_x = x + col and pix_y = y + row, both computed in 11 bits and truncated to 10 for output.
  - pix_we = rowbit[SPRITE_W-1-col] & (x+col < 640) & (y+row < 480).
- Clipped or zero bits still consume one cycle with pix_we=0.
- Stall: if pix_we=1 and pix_ready=0, hold every register. pix_* stay stable until the transfer occurs.
- After col = SPRITE_W-1 advances:
  - If row < SPRITE_H-1, increment row and go to FETCH.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
- A request presented during a draw is ignored until IDLE (req_ready=0). Requests are never queued.
- Reset at any time, including mid-sprite or mid-stall:
  - The next state is IDLE.
  - No done pulse; no further pix_we.
  - Latched request is discarded.
- pix_ready is ignored when pix_we=0.

## Timing
- Reset values: req_ready=1, rom_addr=0, pix_we=0, pix_x=0, pix_y=0, pix_color=0, done=0.
- Acceptance in cycle 0 → FETCH in cycle 1 → first DRAW column in cycle 2.
- With no stalls:
  - Each row takes 1 + SPRITE_W cycles.
  - The last column is in cycle SPRITE_H*(SPRITE_W+1).
  - done is in cycle SPRITE_H*(SPRITE_W+1)+1.
  - req_ready returns in the next cycle.
- Defaults give 136 draw cycles, done in cycle 137, and a new request accepted no earlier than cycle 138.
- Each stalled cycle adds exactly one cycle to all later events.
- ROM is combinational; no extra wait cycle beyond FETCH.

## Structure
- Shared package sprite_pkg holds:
  - screen constants SCREEN_W=640 and SCREEN_H=480;
  - the blitter state enum (IDLE, FETCH, DRAW, DONE);
  - default SPRITE_W/SPRITE_H for ship (16×8) and enemies (8×8).
- No sub-module. The FSM, row/col counters, row shift/index register and clip compare live in one module.
- A ROM mux selecting ship/enemy ROMs belongs to the instantiating level, not the blitter.

## Test plan
- Ship ROM (0x0180 at row 0) at (100,50), pix_ready=1 → row-0 writes only at (107,50) and (108,50). 36 writes total across 8 rows; done in cycle 137.
- Same ship at x=630 → columns 10..15 suppressed. No pix_x ≥ 640 ever; total cycle count unchanged.
- y=475 → rows 5..7 produce no writes; done still in cycle 137.
- pix_ready low for 5 cycles on the first write → pix_x/pix_y/pix_color held stable throughout; done slips to cycle 142.
- Reset asserted in cycle 40 mid-draw → next cycle IDLE, all outputs at reset values, no done pulse. A new request is accepted the following cycle.
- SPRITE_W=8 with an enemy ROM, req_base=0 at (0,0), plus a second req_valid held during the draw → second request accepted only after done (cycle 73). Row 0 (0xC3) writes at x=0,1,6,7.
